// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame buffer: default widths, FSM state
// encoding and frame timing used by benches.
package vga_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // FSM state encoding (2-bit)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COPY    = 2'd2;

    // One full 800x525 VGA frame in pixel clocks
    localparam int FRAME_CYCLES = 420000;

endpackage

// File: rtl/vga_edge_detect.sv
// Registers VSync and produces a single-cycle pulse at the start of the sync
// pulse. Polarity is selected by ACTIVE_LOW (1: falling edge, 0: rising edge).
module vga_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic start
);

    logic vs_q;
    logic vs_d;

    // Next value is simply the current VSync level
    always_comb begin
        vs_d = vsync;
    end

    // Previous-level register, reset to the inactive level so no false start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= ACTIVE_LOW ? 1'b1 : 1'b0;
        end else begin
            vs_q <= vs_d;
        end
    end

    // Start pulse is combinational from the live input and the stored level
    always_comb begin
        if (ACTIVE_LOW) begin
            start = vs_q & ~vsync;
        end else begin
            start = ~vs_q & vsync;
        end
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered display register bank. The system side fills the back bank
// and commits; banks swap at the next sync-pulse start, then the new front is
// copied into the back so the next edit starts from the displayed frame.
// Optional feature: define SWAP_TIMEOUT_EN to force a swap after
// TIMEOUT_CYCLES cycles of waiting in PENDING (VGA output absent).
module vga_frame_buffer
    import vga_pkg::*;
#(
    parameter int ADDR_W           = ADDR_W_DEF,
    parameter int DATA_W           = DATA_W_DEF,
`ifdef SWAP_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES   = 1048575,
`endif
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Commit,
    output logic              Busy,
    output logic              SwapDone,
    input  logic              VSync,
    input  logic [ADDR_W-1:0] MemAddrIN,
    output logic [DATA_W-1:0] MemDataOut
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] bank0_q [DEPTH];
    logic [DATA_W-1:0] bank0_d [DEPTH];
    logic [DATA_W-1:0] bank1_q [DEPTH];
    logic [DATA_W-1:0] bank1_d [DEPTH];

    logic              front_sel_q, front_sel_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              swap_done_q, swap_done_d;

    logic              sync_start;
    logic              swap_go;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    vga_edge_detect #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_edge (
        .clk   (CLK),
        .rst_n (RESET),
        .vsync (VSync),
        .start (sync_start)
    );

`ifdef SWAP_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] tmo_q, tmo_d;

    // Swap on sync start, or when the wait in PENDING has run too long
    always_comb begin
        swap_go = sync_start | (tmo_q == TMO_LAST);
        tmo_d   = 20'd0;
        if (state_q == ST_PENDING && !swap_go) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    // Timeout counter: counts only while PENDING, clears on leaving it
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_q <= 20'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the timeout the swap waits for the sync pulse indefinitely
    always_comb begin
        swap_go = sync_start;
    end
`endif

    // Commit / swap / copy-back sequencing
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        idx_d       = idx_q;
        swap_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (swap_go) begin
                    front_sel_d = ~front_sel_q;
                    idx_d       = '0;
                    state_d     = ST_COPY;
                end
            end
            ST_COPY: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d     = ST_IDLE;
                    swap_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Back-bank write port: host writes in IDLE, copy-back from front in COPY.
    // The back bank is always the one FrontSel does not point at.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = WrAddr;
        wr_data = WrData;
        if (state_q == ST_IDLE) begin
            wr_en = WrEn;
        end else if (state_q == ST_COPY) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = front_sel_q ? bank1_q[idx_q] : bank0_q[idx_q];
        end
    end

    // Next-state of both banks; only the back bank is ever written
    always_comb begin
        bank0_d = bank0_q;
        bank1_d = bank1_q;
        if (wr_en) begin
            if (front_sel_q) begin
                bank0_d[wr_addr] = wr_data;
            end else begin
                bank1_d[wr_addr] = wr_data;
            end
        end
    end

    // Bank storage, cleared by reset so the display starts black
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else begin
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
        end
    end

    // Control state registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            idx_q       <= '0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            idx_q       <= idx_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Outputs: zero-latency front-bank read and status flags
    always_comb begin
        MemDataOut = front_sel_q ? bank1_q[MemAddrIN] : bank0_q[MemAddrIN];
        Busy       = (state_q != ST_IDLE);
        SwapDone   = swap_done_q;
    end

endmodule
